// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } muldiv_state_t;

  localparam int          MD_ITER      = 32;
  localparam logic [31:0] MD_DIVZERO_Q = 32'hFFFFFFFF;

  // Two's-complement negate when neg is set; used both to take magnitudes
  // and to re-apply signs.
  function automatic logic [31:0] cond_neg(input logic [31:0] x, input logic neg);
    return neg ? (~x + 32'd1) : x;
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shared datapath: shift-add multiply or restoring divide.
// Multiply: {rem, acc} is the 64-bit product/multiplier register, m the multiplicand.
// Divide:   rem is the partial remainder, acc shifts dividend out / quotient in, m the divisor.
module muldiv_step
  import muldiv_pkg::*;
(
  input  logic        is_div,
  input  logic [31:0] rem,
  input  logic [31:0] acc,
  input  logic [31:0] m,
  output logic [31:0] rem_next,
  output logic [31:0] acc_next
);

  logic [32:0] sum;
  logic [32:0] rem_sh;
  logic [31:0] diff;
  logic        ge;

  // Single-iteration add-shift or subtract-compare, selected by op class
  always_comb begin
    sum    = {1'b0, rem} + {1'b0, (acc[0] ? m : 32'd0)};
    rem_sh = {rem, acc[31]};
    ge     = (rem_sh >= {1'b0, m});
    // Remainder stays below the divisor, so the low 32 bits carry the full result
    diff   = rem_sh[31:0] - m;
    if (is_div) begin
      rem_next = ge ? diff : rem_sh[31:0];
      acc_next = {acc[30:0], ge};
    end else begin
      rem_next = sum[32:1];
      acc_next = {sum[0], acc[31:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// 32 RUN iterations plus one FIX cycle that applies signs and writes HI/LO.
module muldiv_unit
  import muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        mthi,
  input  logic        mtlo,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  muldiv_state_t state, state_nx;
  muldiv_op_t    op_e;

  logic        is_div_in, is_uns_in, a_neg, b_neg;
  logic        is_div, sa, sb, dz;
  logic [31:0] rem_q, acc_q, m_q;
  logic [31:0] rem_nx, acc_nx;
  logic [4:0]  cnt;
  logic        last;
  logic        load, step_en, fin, mt_en;
  logic [63:0] prod, prod_s;
  logic [31:0] res_hi, res_lo;

  assign op_e      = muldiv_op_t'(op);
  assign is_div_in = (op_e == MD_DIV) || (op_e == MD_DIVU);
  assign is_uns_in = (op_e == MD_MULTU) || (op_e == MD_DIVU);
  assign a_neg     = ~is_uns_in & a[31];
  assign b_neg     = ~is_uns_in & b[31];
  assign last      = (cnt == 5'(MD_ITER - 1));
  assign busy      = (state != IDLE);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (last)  state_nx = FIX;
      FIX:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Per-state control strobes; MTHI/MTLO only when idle and not starting
  always_comb begin
    load    = 1'b0;
    step_en = 1'b0;
    fin     = 1'b0;
    mt_en   = 1'b0;
    case (state)
      IDLE: begin
        load  = start;
        mt_en = ~start;
      end
      RUN:     step_en = 1'b1;
      FIX:     fin     = 1'b1;
      default: ;
    endcase
  end

  muldiv_step u_step (
    .is_div   (is_div),
    .rem      (rem_q),
    .acc      (acc_q),
    .m        (m_q),
    .rem_next (rem_nx),
    .acc_next (acc_nx)
  );

  // Operand capture on start, then one datapath iteration per RUN cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      is_div <= 1'b0;
      sa     <= 1'b0;
      sb     <= 1'b0;
      dz     <= 1'b0;
      rem_q  <= '0;
      acc_q  <= '0;
      m_q    <= '0;
      cnt    <= '0;
    end else if (load) begin
      is_div <= is_div_in;
      sa     <= a_neg;
      sb     <= b_neg;
      dz     <= is_div_in && (b == 32'd0);
      rem_q  <= '0;
      cnt    <= '0;
      // Divide shifts the dividend through acc; multiply shifts the multiplier
      acc_q  <= is_div_in ? cond_neg(a, a_neg) : cond_neg(b, b_neg);
      m_q    <= is_div_in ? cond_neg(b, b_neg) : cond_neg(a, a_neg);
    end else if (step_en) begin
      rem_q  <= rem_nx;
      acc_q  <= acc_nx;
      cnt    <= cnt + 5'd1;
    end
  end

  // Sign fix-up. With a zero divisor the restoring loop leaves |a| in the
  // remainder, so re-applying a's sign returns a unmodified in HI.
  always_comb begin
    prod   = {rem_q, acc_q};
    prod_s = (sa ^ sb) ? (~prod + 64'd1) : prod;
    if (is_div) begin
      res_hi = cond_neg(rem_q, sa);
      res_lo = dz ? MD_DIVZERO_Q : cond_neg(acc_q, sa ^ sb);
    end else begin
      res_hi = prod_s[63:32];
      res_lo = prod_s[31:0];
    end
  end

  // HI/LO: written by FIX or by idle MTHI/MTLO; done pulses only from FIX
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi   <= '0;
      lo   <= '0;
      done <= 1'b0;
    end else begin
      done <= fin;
      if (fin) begin
        hi <= res_hi;
        lo <= res_lo;
      end else if (mt_en) begin
        if (mthi) hi <= a;
        if (mtlo) lo <= a;
      end
    end
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit for the MIPS integer datapath. It sits beside the ALU and consumes the same two register-file operands. It executes MULT, MULTU, DIV and DIVU over multiple cycles into architectural HI/LO registers, which write-back reads for MFHI/MFLO. It also accepts MTHI/MTLO writes. `busy` is the stall request to the control unit.

## Interface
- No parameters; operand width fixed at 32.
- `clk` input 1: rising-edge clock.
- `rst_n` input 1: asynchronous active-low reset.
- `start` input 1: launch operation `op` on operands `a`, `b`.
- `op` input 2: 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
- `a` input 32: operand A (rs); also the data for MTHI/MTLO.
- `b` input 32: operand B (rt).
- `mthi` input 1: write `a` into HI.
- `mtlo` input 1: write `a` into LO.
- `busy` output 1: operation in progress; control stalls MFHI/MFLO and new mul/div.
- `done` output 1: one-cycle pulse, HI/LO just updated by a completed operation.
- `hi` output 32: HI register (product[63:32] / remainder).
- `lo` output 32: LO register (product[31:0] / quotient).

## Operation
- FSM states: IDLE, RUN, FIX.
- `busy` = (state != IDLE).
- IDLE:
  - `start`=1 latches `op`, the operand magnitudes and the sign flags; iteration counter cleared; go to RUN.
  - Signed ops take the two's-complement magnitude of negative operands. Unsigned ops use operands as-is.
- RUN: one iteration per cycle, 32 cycles, then go to FIX.
  - Multiply: shift-add on the 64-bit unsigned magnitude product.
  - Divide: restoring; 33-bit partial remainder; one quotient bit per cycle.
- FIX: apply signs, write HI/LO, pulse `done`, return to IDLE.
  - Signed MULT: negate the 64-bit product if sign(a) xor sign(b).
  - Signed DIV: quotient negated if sign(a) xor sign(b); remainder takes sign of `a`.
- Divide by zero (b==0, DIV or DIVU): LO=0xFFFFFFFF, HI=`a` unmodified. Same latency as any other operation; no exception.
- DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0. Natural wrap, no trap.
- MTHI/MTLO:
  - Honoured only in IDLE with `start`=0; register updates at the next edge.
  - Both asserted together: both written with `a`.
  - Asserted while busy or together with `start`: dropped.
- `start` while busy: ignored; the in-flight operation is unaffected.
- HI/LO hold their old values throughout RUN/FIX and change only at the FIX edge.

## Timing
- Reset (async assert, sync to `clk` on release): state=IDLE, `hi`=0, `lo`=0, `busy`=0, `done`=0, counter=0.
- Reset mid-operation: abort immediately. No `done` is produced for the aborted operation.
- Start sampled at edge t:
  - `busy`=1 from edge t through edge t+33: 32 RUN cycles plus 1 FIX cycle.
  - At edge t+33: HI/LO written, `done`=1 for exactly one cycle, `busy`=0.
- Start-to-result latency: 33 cycles.
- Back-to-back: a new `start` in the `done` cycle is accepted (state is IDLE). That operation's result appears 33 cycles later.
- MTHI/MTLO latency: 1 cycle; `done` is not pulsed.
- All outputs are registered; no combinational path from inputs to outputs.

## Structure
- Shared package `muldiv_pkg`:
  - `muldiv_op_t` enum: MD_MULT, MD_MULTU, MD_DIV, MD_DIVU.
  - `muldiv_state_t` enum: IDLE, RUN, FIX.
  - Constants: `MD_ITER`=32, `MD_DIVZERO_Q`=32'hFFFFFFFF.
- Main decoder imports `muldiv_op_t` when generating `op`.
- One natural sub-module, `muldiv_step`: combinational single-iteration datapath, add-shift or subtract-compare selected by op class. Instantiated once. Everything else inline in `muldiv_unit`.

## Test plan
- MULT a=0xFFFFFFFE (-2), b=3 -> `done` 33 cycles after start edge; HI=0xFFFFFFFF, LO=0xFFFFFFFA; `busy` high exactly 33 cycles.
- MULTU a=b=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001. Then MULT with same operands -> HI=0, LO=1.
- DIV a=0xFFFFFFF9 (-7), b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU a=100, b=7 -> LO=14, HI=2.
- DIVU a=0x12345678, b=0 -> LO=0xFFFFFFFF, HI=0x12345678, normal latency. DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- Busy-time inputs:
  - MULT 5×6 running; pulse `start` with DIVU and `mthi` with a=0xDEAD mid-run -> HI=0, LO=30, single `done`.
  - Then idle `mtlo` a=0xBEEF -> LO=0xBEEF next cycle, no `done`.
- Assert `rst_n`=0 during RUN iteration 10 -> `hi`, `lo`, `busy`, `done` all 0 immediately. After release, no `done` for 40 cycles.
